// File: rtl/compute_arbiter.sv
// compute_arbiter
// Round-robin arbiter that shares a single compute unit between UNIT_COUNT
// requesting processing units. It accepts one request at a time, issues it to
// the compute unit, waits for completion (with a timeout), and returns the
// result to the requesting unit.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   req_valid       : per-unit request (held until req_ready)
//   req_type        : per-unit operation type, 2 bits per unit
//   req_data        : per-unit operand, DATA_W bits per unit
//   req_ready       : one-hot accept strobe (one cycle)
//   rsp_valid       : one-hot response strobe (one cycle)
//   rsp_data        : result, qualified by rsp_valid
//   rsp_error       : timeout flag, qualified by rsp_valid
//   cu_request      : request to the compute unit (held until cu_ready)
//   cu_unit_id      : granted unit id
//   cu_comp_type    : latched operation type
//   cu_data         : latched operand
//   cu_ready        : compute unit accepts request
//   cu_done         : one-cycle completion pulse
//   cu_result       : result, qualified by cu_done
//   busy            : high whenever a transaction is in flight
//   timeout_count   : saturating count of timed-out transactions
module compute_arbiter #(
   parameter int UNIT_COUNT = 4,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [UNIT_COUNT-1:0]        req_valid,
   input  logic [2*UNIT_COUNT-1:0]      req_type,
   input  logic [DATA_W*UNIT_COUNT-1:0] req_data,
   output logic [UNIT_COUNT-1:0]        req_ready,
   output logic [UNIT_COUNT-1:0]        rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic                         rsp_error,
   output logic                         cu_request,
   output logic [$clog2(UNIT_COUNT)-1:0] cu_unit_id,
   output logic [1:0]                   cu_comp_type,
   output logic [DATA_W-1:0]            cu_data,
   input  logic                         cu_ready,
   input  logic                         cu_done,
   input  logic [DATA_W-1:0]            cu_result,
   output logic                         busy,
   output logic [7:0]                   timeout_count
);

   localparam int ID_W = $clog2(UNIT_COUNT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   state_e              state_q,      state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [ID_W-1:0]     grant_q,      grant_d;
   logic [1:0]          type_q,       type_d;
   logic [DATA_W-1:0]   data_q,       data_d;
   logic [DATA_W-1:0]   result_q,     result_d;
   logic                error_q,      error_d;
   logic [7:0]          wait_cnt_q,   wait_cnt_d;
   logic [7:0]          tmo_cnt_q,    tmo_cnt_d;

   logic                found;
   logic [ID_W-1:0]     sel;
   int                  cand;
   logic [1:0]          sel_type;
   logic [DATA_W-1:0]   sel_data;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Round-robin pick: first requester after last_grant, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = 0;
      for (int k = 1; k <= UNIT_COUNT; k++) begin
         cand = int'(last_grant_q) + k;
         if (cand >= UNIT_COUNT) cand = cand - UNIT_COUNT;
         if (!found && req_valid[ID_W'(cand)]) begin
            found = 1'b1;
            sel   = ID_W'(cand);
         end
      end
   end

   // Operand mux for the selected unit (constant-index slices only).
   always_comb begin
      sel_type = '0;
      sel_data = '0;
      for (int u = 0; u < UNIT_COUNT; u++) begin
         if (ID_W'(u) == sel) begin
            sel_type = req_type[2*u +: 2];
            sel_data = req_data[DATA_W*u +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      type_d       = type_q;
      data_d       = data_q;
      result_d     = result_q;
      error_d      = error_q;
      wait_cnt_d   = wait_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_data     = '0;
      rsp_error    = 1'b0;
      cu_request   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               req_ready = UNIT_COUNT'(1) << sel;
               grant_d   = sel;
               type_d    = sel_type;
               data_d    = sel_data;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cu_request = 1'b1;
            if (cu_ready) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // cu_done has priority over a timeout landing on the same cycle.
            if (cu_done) begin
               result_d = cu_result;
               error_d  = 1'b0;
               state_d  = S_RESP;
            end else if (({1'b0, wait_cnt_q} + 9'd1) == 9'(TIMEOUT)) begin
               result_d  = '0;
               error_d   = 1'b1;
               tmo_cnt_d = sat_inc8(tmo_cnt_q);
               state_d   = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            rsp_valid    = UNIT_COUNT'(1) << grant_q;
            rsp_data     = result_q;
            rsp_error    = error_q;
            last_grant_d = grant_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(UNIT_COUNT - 1);
         grant_q      <= '0;
         type_q       <= '0;
         data_q       <= '0;
         result_q     <= '0;
         error_q      <= 1'b0;
         wait_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         type_q       <= type_d;
         data_q       <= data_d;
         result_q     <= result_d;
         error_q      <= error_d;
         wait_cnt_q   <= wait_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign cu_unit_id    = grant_q;
   assign cu_comp_type  = type_q;
   assign cu_data       = data_q;
   assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_compute_arbiter.sv
// Testbench for compute_arbiter: randomized units and compute unit, checked
// against a transaction-level model (pending-request table, round-robin
// pointer, done-cycle vs. timeout rule, saturating timeout tally).
module tb_compute_arbiter;

   localparam int UC  = 4;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [UC-1:0]     req_valid;
   logic [2*UC-1:0]   req_type;
   logic [DW*UC-1:0]  req_data;
   logic [UC-1:0]     req_ready;
   logic [UC-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              rsp_error;
   logic              cu_request;
   logic [1:0]        cu_unit_id;
   logic [1:0]        cu_comp_type;
   logic [DW-1:0]     cu_data;
   logic              cu_ready;
   logic              cu_done;
   logic [DW-1:0]     cu_result;
   logic              busy;
   logic [7:0]        timeout_count;

   compute_arbiter #(.UNIT_COUNT(UC), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_type(req_type), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .cu_request(cu_request), .cu_unit_id(cu_unit_id),
      .cu_comp_type(cu_comp_type), .cu_data(cu_data), .cu_ready(cu_ready),
      .cu_done(cu_done), .cu_result(cu_result), .busy(busy),
      .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit           pend  [UC];
   logic [1:0]   ptype [UC];
   logic [31:0]  pdata [UC];
   int           last_grant;
   int           tmo_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= UC; k++) begin
         int u;
         u = (last_grant + k) % UC;
         if (pend[u]) return u;
      end
      return -1;
   endfunction

   // Pending units present their request; idle units show junk with valid low.
   task automatic drive_reqs();
      for (int u = 0; u < UC; u++) begin
         req_valid[u] = pend[u];
         req_type[2*u +: 2]   = pend[u] ? ptype[u] : 2'($urandom);
         req_data[DW*u +: DW] = pend[u] ? pdata[u] : $urandom;
      end
   endtask

   task automatic refill();
      for (int u = 0; u < UC; u++) begin
         if (!pend[u] && $urandom_range(2, 0) == 0) begin
            pend[u]  = 1'b1;
            ptype[u] = 2'($urandom);
            pdata[u] = $urandom;
         end
      end
   endtask

   task automatic txn(input bit force_tmo, input bit rst_mid);
      int g, rdly, k;
      logic [1:0]  t;
      logic [31:0] d, res;

      // IDLE / accept cycle
      @(negedge clk);
      drive_reqs();
      cu_ready = 1'b0;
      #1;
      g = pick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rsp", 32'(rsp_valid), 32'd0);
      if (g < 0) begin
         check("idle_noready", 32'(req_ready), 32'd0);
         return;
      end
      check("grant", 32'(req_ready), 32'(1) << g);
      t = ptype[g];
      d = pdata[g];
      pend[g] = 1'b0;

      // ISSUE: cu_done here must be ignored
      rdly = $urandom_range(4, 0);
      for (int i = 0; i <= rdly; i++) begin
         @(negedge clk);
         drive_reqs();
         cu_ready  = (i == rdly);
         cu_done   = 1'($urandom);
         cu_result = $urandom;
         #1;
         check("iss_req", 32'(cu_request), 32'd1);
         check("iss_id", 32'(cu_unit_id), 32'(g));
         check("iss_type", 32'(cu_comp_type), 32'(t));
         check("iss_data", cu_data, d);
         check("iss_busy", 32'(busy), 32'd1);
         check("iss_noready", 32'(req_ready), 32'd0);
      end

      // WAIT: done arrives on wait cycle k; k > TMO means never
      k   = (force_tmo || rst_mid) ? TMO + 1 : $urandom_range(TMO + 1, 1);
      res = $urandom;
      for (int w = 1; w <= TMO; w++) begin
         @(negedge clk);
         drive_reqs();
         cu_ready  = 1'b0;
         cu_done   = (w == k);
         cu_result = (w == k) ? res : $urandom;
         if (rst_mid && w == 2) rst = 1'b1;
         #1;
         check("wait_req", 32'(cu_request), 32'd0);
         check("wait_busy", 32'(busy), 32'd1);
         check("wait_rsp", 32'(rsp_valid), 32'd0);
         if (rst_mid && w == 2) begin
            @(negedge clk);
            rst = 1'b0;
            req_valid = '0;
            cu_done = 1'b0;
            #1;
            last_grant = UC - 1;
            tmo_exp = 0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rsp", 32'(rsp_valid), 32'd0);
            check("rst_req", 32'(cu_request), 32'd0);
            check("rst_tmo", 32'(timeout_count), 32'd0);
            check("rst_data", cu_data, 32'd0);
            return;
         end
         if (w == k) break;
      end

      // RESP: cu_done here must be ignored
      @(negedge clk);
      drive_reqs();
      cu_done   = 1'($urandom);
      cu_result = $urandom;
      #1;
      if (k > TMO && tmo_exp < 255) tmo_exp++;
      check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
      check("rsp_data", rsp_data, (k <= TMO) ? res : 32'd0);
      check("rsp_error", 32'(rsp_error), (k <= TMO) ? 32'd0 : 32'd1);
      check("rsp_tmo", 32'(timeout_count), 32'(tmo_exp));
      check("rsp_noready", 32'(req_ready), 32'd0);
      last_grant = g;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_type = '0; req_data = '0;
      cu_ready = 1'b0; cu_done = 1'b0; cu_result = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_req", 32'(cu_request), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_rsp", 32'(rsp_valid), 32'd0);
      check("reset_tmo", 32'(timeout_count), 32'd0);
      check("reset_id", 32'(cu_unit_id), 32'd0);
      check("reset_data", cu_data, 32'd0);

      last_grant = UC - 1;
      tmo_exp    = 0;

      // All units request at once: grants must come 0,1,2,3, then idle
      for (int u = 0; u < UC; u++) begin
         pend[u] = 1'b1; ptype[u] = 2'($urandom); pdata[u] = $urandom;
      end
      for (int i = 0; i < UC + 1; i++) txn(1'b0, 1'b0);
      pend[0] = 1'b1; ptype[0] = 2'd1; pdata[0] = 32'h10;
      txn(1'b0, 1'b0);

      // Random traffic with occasional mid-transaction reset
      for (int i = 0; i < 250; i++) begin
         refill();
         txn(1'b0, $urandom_range(19, 0) == 0);
      end

      // Forced timeouts to drive the counter into saturation
      for (int i = 0; i < 260; i++) begin
         refill();
         if (pick() < 0) begin
            pend[1] = 1'b1; ptype[1] = 2'($urandom); pdata[1] = $urandom;
         end
         txn(1'b1, 1'b0);
      end
      check("tmo_saturated", 32'(timeout_count), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
